cordic_bus_regfile: RTL and testbench

Memory-mapped register front-end for the CORDIC controller, parametrised in data width and job-queue depth. It accepts operand and control writes from a simple valid/ready register bus and queues complete jobs in a FIFO. It dispatches jobs to the controller one at a time with a one-cycle start pulse, captures results and flags on completion, and raises a maskable, sticky interrupt. It replaces the plain bus-to-controller wiring between the system bus and the CORDIC controller.

---
 rtl/cordic_bus_regfile.sv | 237 +++++++++++++++++++++++
 tb/tb_cordic_bus_regfile.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_bus_regfile.sv
// Register-bus front-end for the CORDIC controller: staging registers, job FIFO,
// single-job dispatch FSM, result capture and maskable sticky interrupt.
//
// state    | meaning
// IDLE     | no job in flight; waits for a queued job and controller READY
// DISPATCH | one-cycle start pulse, FIFO head popped
// BUSY     | job running; waits for a completion strobe with READY set
module cordic_bus_regfile #(
    parameter int p_WIDTH       = 32,
    parameter int p_QUEUE_DEPTH = 4,
    parameter int p_ADDR_WIDTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    busValid,
    output logic                    busReady,
    input  logic                    busWrite,
    input  logic [p_ADDR_WIDTH-1:0] busAddr,
    input  logic [p_WIDTH-1:0]      busWriteData,
    output logic [p_WIDTH-1:0]      busReadData,
    output logic                    busReadValid,
    output logic [p_WIDTH-1:0]      xInput,
    output logic [p_WIDTH-1:0]      yInput,
    output logic [p_WIDTH-1:0]      zInput,
    output logic [p_WIDTH-1:0]      controlRegisterInput,
    input  logic [p_WIDTH-1:0]      xResult,
    input  logic [p_WIDTH-1:0]      yResult,
    input  logic [p_WIDTH-1:0]      zResult,
    input  logic [p_WIDTH-1:0]      controlRegisterOutput,
    input  logic                    controlRegisterWriteEnable,
    output logic                    irq
);

    localparam int c_PTR_W = $clog2(p_QUEUE_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    localparam logic [1:0] s_IDLE     = 2'd0;
    localparam logic [1:0] s_DISPATCH = 2'd1;
    localparam logic [1:0] s_BUSY     = 2'd2;

    localparam logic [p_ADDR_WIDTH-1:0] c_A_X_IN   = p_ADDR_WIDTH'(0);
    localparam logic [p_ADDR_WIDTH-1:0] c_A_Y_IN   = p_ADDR_WIDTH'(1);
    localparam logic [p_ADDR_WIDTH-1:0] c_A_Z_IN   = p_ADDR_WIDTH'(2);
    localparam logic [p_ADDR_WIDTH-1:0] c_A_CTRL   = p_ADDR_WIDTH'(3);
    localparam logic [p_ADDR_WIDTH-1:0] c_A_X_RES  = p_ADDR_WIDTH'(4);
    localparam logic [p_ADDR_WIDTH-1:0] c_A_Y_RES  = p_ADDR_WIDTH'(5);
    localparam logic [p_ADDR_WIDTH-1:0] c_A_Z_RES  = p_ADDR_WIDTH'(6);
    localparam logic [p_ADDR_WIDTH-1:0] c_A_STATUS = p_ADDR_WIDTH'(7);
    localparam logic [p_ADDR_WIDTH-1:0] c_A_INT_ST = p_ADDR_WIDTH'(8);
    localparam logic [p_ADDR_WIDTH-1:0] c_A_INT_EN = p_ADDR_WIDTH'(9);

    logic [p_WIDTH-1:0] r_x_in, r_y_in, r_z_in, r_ctrl_last;
    logic [p_WIDTH-1:0] r_x_res, r_y_res, r_z_res;
    logic [1:0]         r_int_sts, r_int_en;
    logic               r_irq;
    logic               r_rd_valid;
    logic [p_WIDTH-1:0] r_rd_data;

    logic [p_WIDTH-1:0] r_q_x [p_QUEUE_DEPTH];
    logic [p_WIDTH-1:0] r_q_y [p_QUEUE_DEPTH];
    logic [p_WIDTH-1:0] r_q_z [p_QUEUE_DEPTH];
    logic [p_WIDTH-1:0] r_q_c [p_QUEUE_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr, r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic [1:0]         r_state;
    logic [p_WIDTH-1:0] r_x_out, r_y_out, r_z_out, r_c_out;

    logic               w_full, w_empty, w_is_ctrl;
    logic               w_acc, w_wr, w_rd, w_push, w_pop;
    logic               w_start, w_done, w_err;
    logic [1:0]         w_int_set, w_int_clr;
    logic [p_WIDTH-1:0] w_status, w_rd_mux;
    logic               w_unused_flags;

    assign w_full    = (r_count == c_CNT_W'(p_QUEUE_DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_is_ctrl = (busAddr == c_A_CTRL);

    // Only a CONTROL write into a full queue is held off; fullness uses the pre-edge count.
    assign busReady = ~(busValid & busWrite & w_is_ctrl & w_full);
    assign w_acc    = busValid & busReady;
    assign w_wr     = w_acc & busWrite;
    assign w_rd     = w_acc & ~busWrite;
    assign w_push   = w_wr & w_is_ctrl;
    assign w_pop    = (r_state == s_DISPATCH);

    assign w_start = (r_state == s_IDLE) & ~w_empty & controlRegisterOutput[16];
    assign w_done  = (r_state == s_BUSY) & controlRegisterWriteEnable & controlRegisterOutput[16];
    assign w_err   = |controlRegisterOutput[18:17];

    assign w_int_set = {w_done & w_err, w_done};
    assign w_int_clr = (w_wr && busAddr == c_A_INT_ST) ? busWriteData[1:0] : 2'b00;

    assign w_unused_flags = ^controlRegisterOutput;

    always_comb begin
        w_status                 = '0;
        w_status[31:16]          = controlRegisterOutput[31:16];
        w_status[8 +: c_CNT_W]   = r_count;
        w_status[0]              = (r_state != s_IDLE);
    end

    always_comb begin
        w_rd_mux = '0;
        case (busAddr)
            c_A_X_IN:   w_rd_mux = r_x_in;
            c_A_Y_IN:   w_rd_mux = r_y_in;
            c_A_Z_IN:   w_rd_mux = r_z_in;
            c_A_CTRL:   w_rd_mux = r_ctrl_last;
            c_A_X_RES:  w_rd_mux = r_x_res;
            c_A_Y_RES:  w_rd_mux = r_y_res;
            c_A_Z_RES:  w_rd_mux = r_z_res;
            c_A_STATUS: w_rd_mux = w_status;
            c_A_INT_ST: w_rd_mux = {{(p_WIDTH-2){1'b0}}, r_int_sts};
            c_A_INT_EN: w_rd_mux = {{(p_WIDTH-2){1'b0}}, r_int_en};
            default:    w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x_in      <= '0;
            r_y_in      <= '0;
            r_z_in      <= '0;
            r_ctrl_last <= '0;
            r_int_en    <= '0;
        end else if (w_wr) begin
            case (busAddr)
                c_A_X_IN:   r_x_in      <= busWriteData;
                c_A_Y_IN:   r_y_in      <= busWriteData;
                c_A_Z_IN:   r_z_in      <= busWriteData;
                c_A_CTRL:   r_ctrl_last <= busWriteData;
                c_A_INT_EN: r_int_en    <= busWriteData[1:0];
                default:    ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_valid <= w_rd;
            if (w_rd) begin
                r_rd_data <= w_rd_mux;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_x[r_wr_ptr] <= r_x_in;
            r_q_y[r_wr_ptr] <= r_y_in;
            r_q_z[r_wr_ptr] <= r_z_in;
            r_q_c[r_wr_ptr] <= busWriteData;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
        end
    end

    // Operands are loaded on the way into DISPATCH so the start pulse sees them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= s_IDLE;
            r_x_out <= '0;
            r_y_out <= '0;
            r_z_out <= '0;
            r_c_out <= '0;
        end else begin
            case (r_state)
                s_IDLE: begin
                    if (w_start) begin
                        r_state <= s_DISPATCH;
                        r_x_out <= r_q_x[r_rd_ptr];
                        r_y_out <= r_q_y[r_rd_ptr];
                        r_z_out <= r_q_z[r_rd_ptr];
                        r_c_out <= r_q_c[r_rd_ptr] | p_WIDTH'(1);
                    end
                end
                s_DISPATCH: begin
                    r_state    <= s_BUSY;
                    r_c_out[0] <= 1'b0;
                end
                s_BUSY: begin
                    if (w_done) begin
                        r_state <= s_IDLE;
                    end
                end
                default: r_state <= s_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x_res   <= '0;
            r_y_res   <= '0;
            r_z_res   <= '0;
            r_int_sts <= '0;
            r_irq     <= 1'b0;
        end else begin
            if (w_done) begin
                r_x_res <= xResult;
                r_y_res <= yResult;
                r_z_res <= zResult;
            end
            // A hardware set overrides a same-cycle write-1-to-clear.
            r_int_sts <= (r_int_sts & ~w_int_clr) | w_int_set;
            r_irq     <= |(r_int_sts & r_int_en);
        end
    end

    assign busReadData          = r_rd_data;
    assign busReadValid         = r_rd_valid;
    assign xInput               = r_x_out;
    assign yInput               = r_y_out;
    assign zInput               = r_z_out;
    assign controlRegisterInput = r_c_out;
    assign irq                  = r_irq;

endmodule

// File: tb/tb_cordic_bus_regfile.sv
// Directed/randomised bench for cordic_bus_regfile: a job-level model (queue of
// pending jobs, result and interrupt registers) predicts every bus read and dispatch.
module tb_cordic_bus_regfile;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        busValid = 1'b0, busWrite = 1'b0;
    logic        busReady;
    logic [3:0]  busAddr = '0;
    logic [31:0] busWriteData = '0;
    logic [31:0] busReadData;
    logic        busReadValid;
    logic [31:0] xInput, yInput, zInput, controlRegisterInput;
    logic [31:0] xResult = '0, yResult = '0, zResult = '0;
    logic [31:0] cro = '0;
    logic        cre = 1'b0;
    logic        irq;

    cordic_bus_regfile dut (
        .clk                        (clk),
        .rst                        (rst),
        .busValid                   (busValid),
        .busReady                   (busReady),
        .busWrite                   (busWrite),
        .busAddr                    (busAddr),
        .busWriteData               (busWriteData),
        .busReadData                (busReadData),
        .busReadValid               (busReadValid),
        .xInput                     (xInput),
        .yInput                     (yInput),
        .zInput                     (zInput),
        .controlRegisterInput       (controlRegisterInput),
        .xResult                    (xResult),
        .yResult                    (yResult),
        .zResult                    (zResult),
        .controlRegisterOutput      (cro),
        .controlRegisterWriteEnable (cre),
        .irq                        (irq)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model state
    logic [31:0]  m_x, m_y, m_z, m_ctrl, m_xr, m_yr, m_zr;
    logic [1:0]   m_ists, m_ien;
    logic [127:0] exp_q[$];
    logic [127:0] act_q[$];

    always @(negedge clk) begin
        if (!rst && controlRegisterInput[0])
            act_q.push_back({xInput, yInput, zInput, controlRegisterInput});
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_x = '0; m_y = '0; m_z = '0; m_ctrl = '0;
        m_xr = '0; m_yr = '0; m_zr = '0;
        m_ists = '0; m_ien = '0;
        exp_q.delete();
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] status_exp(input int cnt, input bit inflight);
        return {cro[31:16], 8'(cnt), 7'b0, inflight};
    endfunction

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        bit ok = 0;
        busValid = 1; busWrite = 1; busAddr = a; busWriteData = d;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (busReady) begin ok = 1; break; end
        end
        chk("wr_accept", ok, 1);
        @(posedge clk); #1;
        busValid = 0; busWrite = 0;
        case (a)
            4'd0: m_x = d;
            4'd1: m_y = d;
            4'd2: m_z = d;
            4'd3: begin m_ctrl = d; exp_q.push_back({m_x, m_y, m_z, d | 32'h1}); end
            4'd8: m_ists = m_ists & ~d[1:0];
            4'd9: m_ien = d[1:0];
            default: ;
        endcase
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        busValid = 1; busWrite = 0; busAddr = a;
        @(posedge clk); #1;
        busValid = 0;
        @(negedge clk);
        chk("rd_valid", busReadValid, 1);
        d = busReadData;
        @(posedge clk); #1;
    endtask

    task automatic check_read(input string tag, input logic [3:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        chk(tag, d, exp);
    endtask

    task automatic push_job();
        bus_write(4'd0, $urandom);
        bus_write(4'd1, $urandom);
        bus_write(4'd2, $urandom);
        bus_write(4'd3, $urandom);
    endtask

    task automatic complete(input logic [31:0] xr, input logic [31:0] yr,
                            input logic [31:0] zr, input logic [31:0] flags);
        xResult = xr; yResult = yr; zResult = zr; cro = flags; cre = 1;
        @(posedge clk); #1;
        cre = 0;
        if (flags[16]) begin
            m_xr = xr; m_yr = yr; m_zr = zr;
            m_ists = m_ists | {|flags[18:17], 1'b1};
        end
    endtask

    // Waits for the next start pulse and compares it with the oldest pending job.
    task automatic run_job_check(input string tag);
        logic [127:0] got = '1;
        logic [127:0] want = '0;
        for (int k = 0; k < 40; k++) begin
            if (act_q.size() > 0) break;
            @(negedge clk);
        end
        chk({tag, "_seen"}, act_q.size() > 0, 1);
        if (act_q.size() > 0) got = act_q.pop_front();
        if (exp_q.size() > 0) want = exp_q.pop_front();
        chk(tag, got, want);
        @(posedge clk); #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] d, rx, ry, rz, c5;
        int n0;
        model_reset();

        // Reset values
        #12;
        chk("rst_busReady", busReady, 1);
        chk("rst_readValid", busReadValid, 0);
        chk("rst_readData", busReadData, 0);
        chk("rst_irq", irq, 0);
        chk("rst_xInput", xInput, 0);
        chk("rst_ctrlIn", controlRegisterInput, 0);
        @(posedge clk); #1;
        rst = 0;
        tick(2);
        check_read("rst_status", 4'd7, status_exp(0, 0));

        // Basic dispatch with exact start-pulse timing
        cro = 32'h0001_0000;
        bus_write(4'd0, 32'h100);
        bus_write(4'd1, 32'h200);
        bus_write(4'd2, 32'h300);
        bus_write(4'd3, 32'h0000_0A04);
        @(negedge clk);
        chk("start_not_early", controlRegisterInput, 0);
        @(negedge clk);
        chk("start_pulse", controlRegisterInput, 32'h0000_0A05);
        chk("start_ops", {xInput, yInput, zInput}, {32'h100, 32'h200, 32'h300});
        @(negedge clk);
        chk("start_cleared", controlRegisterInput, 32'h0000_0A04);
        @(posedge clk); #1;
        run_job_check("job1");
        check_read("busy_status", 4'd7, status_exp(0, 1));
        check_read("ctrl_readback", 4'd3, 32'h0000_0A04);
        check_read("x_in_readback", 4'd0, 32'h100);

        // Completion and interrupt
        bus_write(4'd9, 32'h1);
        complete(32'h11, 32'h22, 32'h33, 32'h0001_0000);
        @(negedge clk);
        chk("irq_delay", irq, 0);
        @(negedge clk);
        chk("irq_set", irq, 1);
        @(posedge clk); #1;
        check_read("x_res", 4'd4, m_xr);
        check_read("y_res", 4'd5, m_yr);
        check_read("z_res", 4'd6, m_zr);
        check_read("int_sts_done", 4'd8, {30'd0, m_ists});
        bus_write(4'd8, 32'h1);
        tick(1);
        @(negedge clk);
        chk("irq_cleared", irq, 0);
        @(posedge clk); #1;

        // Full FIFO back-pressure and FIFO order
        cro = 32'h0;
        for (int i = 0; i < 4; i++) push_job();
        check_read("full_status", 4'd7, status_exp(4, 0));
        bus_write(4'd0, $urandom);
        bus_write(4'd1, $urandom);
        bus_write(4'd2, $urandom);
        c5 = $urandom;
        busValid = 1; busWrite = 1; busAddr = 4'd3; busWriteData = c5;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("full_stall", busReady, 0);
        end
        cro = 32'h0001_0000;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (busReady) break;
        end
        chk("full_release", busReady, 1);
        chk("pop_before_accept", act_q.size(), 1);
        @(posedge clk); #1;
        busValid = 0; busWrite = 0;
        m_ctrl = c5;
        exp_q.push_back({m_x, m_y, m_z, c5 | 32'h1});
        for (int i = 0; i < 5; i++) begin
            run_job_check("fifo_order");
            rx = $urandom; ry = $urandom; rz = $urandom;
            complete(rx, ry, rz, 32'h0001_0000 | ($urandom_range(0, 3) << 17));
            if (i < 2) check_read("rand_x_res", 4'd4, m_xr);
        end
        check_read("rand_z_res", 4'd6, m_zr);
        check_read("rand_int_sts", 4'd8, {30'd0, m_ists});
        check_read("drained_status", 4'd7, status_exp(0, 0));

        // Error flag and W1C/set collision
        bus_write(4'd8, 32'h3);
        bus_write(4'd9, 32'h2);
        push_job();
        run_job_check("err_job");
        complete($urandom, $urandom, $urandom, 32'h0004_0000);
        check_read("flag_only_status", 4'd7, status_exp(0, 1));
        check_read("flag_only_ists", 4'd8, {30'd0, m_ists});
        complete($urandom, $urandom, $urandom, 32'h0005_0000);
        tick(1);
        @(negedge clk);
        chk("err_irq", irq, 1);
        @(posedge clk); #1;
        check_read("err_ists", 4'd8, {30'd0, m_ists});
        push_job();
        run_job_check("collide_job");
        xResult = $urandom; yResult = $urandom; zResult = $urandom;
        cro = 32'h0001_0000; cre = 1;
        busValid = 1; busWrite = 1; busAddr = 4'd8; busWriteData = 32'h1;
        @(posedge clk); #1;
        cre = 0; busValid = 0; busWrite = 0;
        m_xr = xResult;
        m_ists = (m_ists & ~2'b01) | 2'b01;
        check_read("collide_ists", 4'd8, {30'd0, m_ists});
        check_read("collide_x_res", 4'd4, m_xr);

        // Reset while busy with two jobs queued
        push_job();
        run_job_check("pre_rst_job");
        push_job();
        push_job();
        check_read("pre_rst_status", 4'd7, status_exp(2, 1));
        rst = 1;
        #1;
        chk("mid_rst_ctrlIn", controlRegisterInput, 0);
        chk("mid_rst_ops", {xInput, yInput, zInput}, 96'd0);
        chk("mid_rst_irq", irq, 0);
        chk("mid_rst_ready", busReady, 1);
        chk("mid_rst_rdvalid", busReadValid, 0);
        model_reset();
        @(posedge clk); #1;
        rst = 0;
        n0 = act_q.size();
        tick(10);
        chk("no_start_after_rst", act_q.size(), n0);
        check_read("rst_x_res", 4'd4, 32'h0);
        check_read("rst_int_en", 4'd9, 32'h0);
        check_read("rst_status2", 4'd7, status_exp(0, 0));
        bus_write(4'd3, $urandom);
        run_job_check("post_rst_job");

        // Unmapped address and back-to-back reads
        bus_write(4'hF, $urandom);
        check_read("unmapped", 4'hF, 32'h0);
        bus_write(4'd0, 32'hCAFE_0001);
        bus_write(4'd9, 32'h3);
        busValid = 1; busWrite = 0; busAddr = 4'd0;
        @(posedge clk); #1;
        busAddr = 4'd9;
        @(negedge clk);
        chk("b2b_valid0", busReadValid, 1);
        chk("b2b_data0", busReadData, m_x);
        @(posedge clk); #1;
        busValid = 0;
        @(negedge clk);
        chk("b2b_valid1", busReadValid, 1);
        chk("b2b_data1", busReadData, {30'd0, m_ien});
        @(negedge clk);
        chk("b2b_valid_drop", busReadValid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
